abs_sign_pipe: RTL

ABS_SIGN_PIPE -- requirements
Module: abs_sign_pipe

---
 rtl/abs_pkg.sv | 10 +
 rtl/abs_lane.sv | 34 +++
 rtl/abs_sign_pipe.sv | 138 +++++++++++++
 3 files changed

// File: rtl/abs_pkg.sv
// Shared defaults and lane type for the abs_sign_pipe block.
package abs_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LANES = 4;
  localparam int DEF_CNT_W = 16;

  typedef logic signed [DEF_WIDTH-1:0] lane_t;

endpackage

// File: rtl/abs_lane.sv
// One lane of the magnitude datapath: sign split plus XOR before stage 1, increment and
// optional most-negative saturation (macro ABS_SAT_EN) after stage 1.
module abs_lane
  import abs_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic signed [WIDTH-1:0] lane_i,
  output logic                    sign_o,
  output logic        [WIDTH-1:0] inv_o,
  input  logic        [WIDTH-1:0] inv_i,
  input  logic                    sign_i,
  output logic        [WIDTH-1:0] mag_o,
  output logic                    sat_o
);

  logic [WIDTH-1:0] sum;

  assign sign_o = lane_i[WIDTH-1];
  assign inv_o  = lane_i ^ {WIDTH{sign_o}};
  assign sum    = inv_i + {{(WIDTH-1){1'b0}}, sign_i};

`ifdef ABS_SAT_EN
  // Only the most-negative input can set the MSB after negation; clamp it to the max positive.
  logic ovf;
  assign ovf   = sign_i & sum[WIDTH-1];
  assign mag_o = ovf ? inv_i : sum;
  assign sat_o = ovf;
`else
  assign mag_o = sum;
  assign sat_o = 1'b0;
`endif

endmodule

// File: rtl/abs_sign_pipe.sv
// Two-stage per-lane absolute value with sign/saturation flags and a saturating negative-lane
// counter. Optional most-negative saturation is enabled by defining ABS_SAT_EN.
module abs_sign_pipe
  import abs_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_mag,
  output logic [LANES-1:0]       out_sign,
  output logic [LANES-1:0]       out_sat,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       neg_cnt
);

  localparam int PCW   = $clog2(LANES + 1);
  localparam int SUM_W = CNT_W + PCW + 1;

  function automatic logic [PCW-1:0] popcount(input logic [LANES-1:0] v);
    logic [PCW-1:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) c = c + PCW'(v[i]);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PCW-1:0]   b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({CNT_W{1'b1}})) return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
  endfunction

  logic [LANES-1:0]       sign_p0;
  logic [LANES*WIDTH-1:0] inv_p0;

  logic                   vld_p1_q, vld_p1_d;
  logic [LANES-1:0]       sign_p1_q, sign_p1_d;
  logic [LANES*WIDTH-1:0] inv_p1_q, inv_p1_d;
  logic [LANES*WIDTH-1:0] mag_p1;
  logic [LANES-1:0]       sat_p1;

  logic                   vld_p2_q, vld_p2_d;
  logic [LANES*WIDTH-1:0] mag_p2_q, mag_p2_d;
  logic [LANES-1:0]       sign_p2_q, sign_p2_d;
  logic [LANES-1:0]       sat_p2_q, sat_p2_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic load_p1, load_p2, in_fire, out_fire;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    abs_lane #(.WIDTH(WIDTH)) u_lane (
      .lane_i (in_data[g*WIDTH +: WIDTH]),
      .sign_o (sign_p0[g]),
      .inv_o  (inv_p0[g*WIDTH +: WIDTH]),
      .inv_i  (inv_p1_q[g*WIDTH +: WIDTH]),
      .sign_i (sign_p1_q[g]),
      .mag_o  (mag_p1[g*WIDTH +: WIDTH]),
      .sat_o  (sat_p1[g])
    );
  end

  // A stage loads when empty or when its current contents leave on this edge.
  assign load_p2  = !vld_p2_q || out_ready;
  assign load_p1  = !vld_p1_q || load_p2;
  assign in_ready = load_p1;
  assign in_fire  = in_valid && load_p1;
  assign out_fire = vld_p2_q && out_ready;

  always_comb begin
    vld_p1_d  = vld_p1_q;
    sign_p1_d = sign_p1_q;
    inv_p1_d  = inv_p1_q;
    vld_p2_d  = vld_p2_q;
    mag_p2_d  = mag_p2_q;
    sign_p2_d = sign_p2_q;
    sat_p2_d  = sat_p2_q;
    cnt_d     = cnt_q;

    // Stage 0 -> 1: sign and conditionally inverted lane
    if (load_p1) vld_p1_d = in_valid;
    if (in_fire) begin
      sign_p1_d = sign_p0;
      inv_p1_d  = inv_p0;
    end

    // Stage 1 -> 2: add sign as increment, flag saturation
    if (load_p2) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        mag_p2_d  = mag_p1;
        sign_p2_d = sign_p1_q;
        sat_p2_d  = sat_p1;
      end
    end

    if (cnt_clr)       cnt_d = '0;
    else if (out_fire) cnt_d = sat_add(cnt_q, popcount(sign_p2_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      mag_p2_q  <= '0;
      sign_p2_q <= '0;
      sat_p2_q  <= '0;
      cnt_q     <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      mag_p2_q  <= mag_p2_d;
      sign_p2_q <= sign_p2_d;
      sat_p2_q  <= sat_p2_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    sign_p1_q <= sign_p1_d;
    inv_p1_q  <= inv_p1_d;
  end

  assign out_valid = vld_p2_q;
  assign out_mag   = mag_p2_q;
  assign out_sign  = sign_p2_q;
  assign out_sat   = sat_p2_q;
  assign neg_cnt   = cnt_q;

endmodule
